// File: rtl/ex_pkg.sv
// Shared definitions for the execute stage: ALU operation codes and FSM states.
package ex_pkg;

    localparam int ALU_OP_W = 3;

    localparam logic [ALU_OP_W-1:0] OP_ADD = 3'b000;
    localparam logic [ALU_OP_W-1:0] OP_SUB = 3'b001;
    localparam logic [ALU_OP_W-1:0] OP_AND = 3'b010;
    localparam logic [ALU_OP_W-1:0] OP_OR  = 3'b011;
    localparam logic [ALU_OP_W-1:0] OP_SLT = 3'b100;
    localparam logic [ALU_OP_W-1:0] OP_SLL = 3'b101;
    localparam logic [ALU_OP_W-1:0] OP_SRL = 3'b110;
    localparam logic [ALU_OP_W-1:0] OP_MUL = 3'b111;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } ex_state_e;

endpackage

// File: rtl/ex_stage_seq_multiplier.sv
// Iterative shift-add multiplier: one partial product per cycle, DATA_W steps.
// done pulses combinationally during the final step; product is valid with it.
module seq_multiplier #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    output logic              done,
    output logic [DATA_W-1:0] product
);
    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

    logic              active_q, active_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0] acc_step;

    // Partial-product add for the current step; the last step's sum is the product.
    always_comb begin
        acc_step = acc_q + (b_q[0] ? a_q : '0);
        done     = active_q && (cnt_q == LAST_CNT);
        product  = acc_step;
    end

    // Next-state: capture operands on start, otherwise shift A left / B right each step.
    always_comb begin
        active_d = active_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        if (start) begin
            active_d = 1'b1;
            cnt_d    = '0;
            a_d      = A;
            b_d      = B;
            acc_d    = '0;
        end else if (active_q) begin
            acc_d = acc_step;
            a_d   = a_q << 1;
            b_d   = b_q >> 1;
            cnt_d = cnt_q + 1'b1;
            if (done) begin
                active_d = 1'b0;
            end
        end
    end

    // Datapath registers; reset discards any in-flight multiplication.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_q <= 1'b0;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
        end else begin
            active_q <= active_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
        end
    end

endmodule

// File: rtl/ex_stage.sv
// Pipelined execute stage: operand mux, single-cycle ALU, multi-cycle MUL,
// and a registered EX/MEM output with valid/ready handshake on both sides.
module ex_stage
    import ex_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int SH_W   = $clog2(DATA_W)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                inValid,
    output logic                inReady,
    input  logic [DATA_W-1:0]   readData1,
    input  logic [DATA_W-1:0]   readData2,
    input  logic [DATA_W-1:0]   instant,
    input  logic                aluSrc,
    input  logic [ALU_OP_W-1:0] aluOp,
    output logic                outValid,
    input  logic                outReady,
    output logic [DATA_W-1:0]   aluOut,
    output logic                zero,
    output logic                busy
);
    ex_state_e         state_q, state_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] alu_out_q, alu_out_d;
    logic              zero_q, zero_d;

    logic [DATA_W-1:0] op_b;
    logic [DATA_W-1:0] alu_res;
    logic              accept;
    logic              is_mul;
    logic              mul_start;
    logic              mul_done;
    logic [DATA_W-1:0] mul_product;

    // Operand B selection and the single-cycle ALU.
    always_comb begin
        op_b = aluSrc ? instant : readData2;
        unique case (aluOp)
            OP_ADD:  alu_res = readData1 + op_b;
            OP_SUB:  alu_res = readData1 - op_b;
            OP_AND:  alu_res = readData1 & op_b;
            OP_OR:   alu_res = readData1 | op_b;
            OP_SLT:  alu_res = {{(DATA_W-1){1'b0}}, ($signed(readData1) < $signed(op_b))};
            OP_SLL:  alu_res = readData1 << op_b[SH_W-1:0];
            OP_SRL:  alu_res = readData1 >> op_b[SH_W-1:0];
            default: alu_res = '0;
        endcase
    end

    assign inReady   = (state_q == IDLE) && (!out_valid_q || outReady);
    assign accept    = inValid && inReady;
    assign is_mul    = (aluOp == OP_MUL);
    assign mul_start = accept && is_mul;

    seq_multiplier #(
        .DATA_W(DATA_W)
    ) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .A       (readData1),
        .B       (op_b),
        .done    (mul_done),
        .product (mul_product)
    );

    // FSM next state plus output-register load/consume decisions.
    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        alu_out_d   = alu_out_q;
        zero_d      = zero_q;
        if (out_valid_q && outReady) begin
            out_valid_d = 1'b0;
        end
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (is_mul) begin
                        state_d = MUL;
                    end else begin
                        out_valid_d = 1'b1;
                        alu_out_d   = alu_res;
                        zero_d      = (alu_res == '0);
                    end
                end
            end
            MUL: begin
                // The output register was drained before the MUL was accepted,
                // so completion never overwrites an unconsumed result.
                if (mul_done) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b1;
                    alu_out_d   = mul_product;
                    zero_d      = (mul_product == '0);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and EX/MEM output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            alu_out_q   <= '0;
            zero_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            alu_out_q   <= alu_out_d;
            zero_q      <= zero_d;
        end
    end

    assign outValid = out_valid_q;
    assign aluOut   = alu_out_q;
    assign zero     = zero_q;
    assign busy     = (state_q == MUL);

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: driver pushes reference results on accept,
// monitor compares whatever the stage presents.
module tb_ex_stage;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          inValid = 1'b0;
    logic          inReady;
    logic [DW-1:0] readData1 = '0;
    logic [DW-1:0] readData2 = '0;
    logic [DW-1:0] instant = '0;
    logic          aluSrc = 1'b0;
    logic [2:0]    aluOp = 3'b000;
    logic          outValid;
    logic          outReady = 1'b1;
    logic [DW-1:0] aluOut;
    logic          zero;
    logic          busy;

    int asserts = 0;
    int fails   = 0;
    int txn_no  = 0;
    bit rand_done = 1'b0;
    logic [DW-1:0] sb[$];

    ex_stage #(.DATA_W(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .inValid   (inValid),
        .inReady   (inReady),
        .readData1 (readData1),
        .readData2 (readData2),
        .instant   (instant),
        .aluSrc    (aluSrc),
        .aluOp     (aluOp),
        .outValid  (outValid),
        .outReady  (outReady),
        .aluOut    (aluOut),
        .zero      (zero),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Reference behaviour written directly from the operation table.
    function automatic logic [DW-1:0] ref_model(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                                input logic [2:0] op);
        longint unsigned pa, pb, p;
        pa = longint'(a);
        pb = longint'(b);
        case (op)
            3'd0: p = pa + pb;
            3'd1: p = pa - pb;
            3'd2: p = pa & pb;
            3'd3: p = pa | pb;
            3'd4: p = ($signed(a) < $signed(b)) ? 1 : 0;
            3'd5: p = pa << (pb % DW);
            3'd6: p = pa >> (pb % DW);
            default: p = pa * pb;
        endcase
        return p[DW-1:0];
    endfunction

    function automatic logic [DW-1:0] rnd16();
        case ($urandom % 4)
            0: return '0;
            1: return '1;
            default: return DW'($urandom);
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        asserts++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Present one bundle, hold it until accepted, record the expected result.
    task automatic send(input logic [DW-1:0] a, input logic [DW-1:0] r2, input logic [DW-1:0] imm,
                        input logic src, input logic [2:0] op);
        bit ok;
        ok = 1'b0;
        readData1 = a;
        readData2 = r2;
        instant   = imm;
        aluSrc    = src;
        aluOp     = op;
        inValid   = 1'b1;
        for (int i = 0; i < 64 && !ok; i++) begin
            @(negedge clk);
            if (inReady) begin
                sb.push_back(ref_model(a, src ? imm : r2, op));
                ok = 1'b1;
            end
        end
        if (!ok) begin
            asserts++;
            fails++;
            $display("FAIL accept_timeout: got inReady=0 for 64 cycles expected accept");
        end
        @(posedge clk);
        #1;
        inValid = 1'b0;
    endtask

    // Monitor: compare the presented result with the scoreboard head.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (busy) chk("inReady_while_busy", 32'(inReady), 32'd0);
                if (outValid) begin
                    if (sb.size() == 0) begin
                        asserts++;
                        fails++;
                        $display("FAIL unexpected_output: got aluOut=0x%0h expected no result", aluOut);
                    end else begin
                        chk("aluOut", 32'(aluOut), 32'(sb[0]));
                        chk("zero", 32'(zero), 32'(sb[0] == '0));
                        if (outReady) begin
                            txn_no++;
                            $display("txn %0d: aluOut=0x%04h zero=%0b expected=0x%04h",
                                     txn_no, aluOut, zero, sb[0]);
                            void'(sb.pop_front());
                        end
                    end
                end
            end
        end
    end

    initial begin
        int k;
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_outValid", 32'(outValid), 0);
        chk("rst_aluOut", 32'(aluOut), 0);
        chk("rst_zero", 32'(zero), 1);
        chk("rst_busy", 32'(busy), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_inReady", 32'(inReady), 1);

        // Mid-MUL reset discards the multiplication
        @(posedge clk);
        #1;
        send(16'd7, 16'd9, 16'd0, 1'b0, 3'd7);
        repeat (5) @(posedge clk);
        #1;
        chk("midmul_busy_before", 32'(busy), 1);
        rst = 1'b1;
        #1;
        sb.delete();
        chk("midmul_outValid", 32'(outValid), 0);
        chk("midmul_aluOut", 32'(aluOut), 0);
        chk("midmul_zero", 32'(zero), 1);
        chk("midmul_busy", 32'(busy), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midmul_inReady", 32'(inReady), 1);
        @(posedge clk);
        #1;

        // Directed ALU operations
        send(16'd10, 16'd20, 16'd99, 1'b0, 3'd0);
        send(16'd10, 16'd77, 16'd3, 1'b1, 3'd0);
        send(16'd10, 16'd5, 16'd10, 1'b1, 3'd1);
        send(16'hFFFF, 16'd1, 16'd0, 1'b0, 3'd4);
        send(16'd1, 16'h0013, 16'd0, 1'b0, 3'd5);
        send(16'h8000, 16'd15, 16'd0, 1'b0, 3'd6);
        send(16'hFFFF, 16'd1, 16'd0, 1'b0, 3'd0);
        send(16'hF0F0, 16'h0FF0, 16'd0, 1'b0, 3'd2);
        send(16'hF000, 16'h000F, 16'd0, 1'b0, 3'd3);
        repeat (2) @(posedge clk);
        #1;

        // MUL latency, busy and refusal of new bundles while iterating
        send(16'd300, 16'd300, 16'd0, 1'b0, 3'd7);
        readData1 = 16'd1;
        readData2 = 16'd2;
        aluOp     = 3'd0;
        inValid   = 1'b1;
        k = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            k++;
            #1;
            if (outValid) break;
            chk("mul_busy", 32'(busy), 1);
            chk("mul_inReady", 32'(inReady), 0);
        end
        inValid = 1'b0;
        chk("mul_latency", 32'(k), 32'd16);
        chk("mul_value", 32'(aluOut), 32'h5F90);
        repeat (2) @(posedge clk);
        #1;

        // Backpressure: first result held, second accepted on the consume edge
        outReady = 1'b0;
        send(16'd5, 16'd6, 16'd0, 1'b0, 3'd0);
        fork
            send(16'd7, 16'd8, 16'd0, 1'b0, 3'd0);
            begin
                repeat (4) begin
                    @(negedge clk);
                    chk("bp_inReady", 32'(inReady), 0);
                    chk("bp_hold", 32'(aluOut), 32'd11);
                end
                @(posedge clk);
                #1;
                outReady = 1'b1;
            end
        join
        chk("bp_outValid", 32'(outValid), 1);
        chk("bp_new", 32'(aluOut), 32'd15);
        repeat (2) @(posedge clk);
        #1;

        // Randomized traffic with random backpressure
        fork
            begin
                for (int n = 0; n < 120; n++) begin
                    logic [2:0] op;
                    op = 3'($urandom_range(0, 7));
                    send(rnd16(), rnd16(), rnd16(), 1'($urandom % 2), op);
                    if ($urandom % 3 == 0) begin
                        @(posedge clk);
                        #1;
                    end
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1;
                    outReady = ($urandom % 4) != 0;
                end
            end
        join
        outReady = 1'b1;
        for (int i = 0; i < 50 && sb.size() != 0; i++) @(posedge clk);
        #1;
        chk("drain_empty", 32'(sb.size()), 0);
        chk("drain_outValid", 32'(outValid), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule
